cmd_frame_responder: RTL and testbench
======================================

Name: cmd_frame_responder

Overview:
Copter-side end of the wireless command link; counterpart to the base-station CommMaster.
- Assembles 3-byte command frames (opcode, data high byte, data low byte) from the UART receiver's byte interface into cmd/data with a cmd_rdy handshake for the command processor.
- Serialises the single-byte response (positive ack 8'hA5, battery reading, etc.) back onto TX as 8N1 UART.
- Sits between the UART receiver and the command configuration logic inside QuadCopter.

Parameters:
BAUD_DIV, 2604, clk cycles per UART bit (50 MHz / 19200 baud).
FRAME_TMO, 22'd2500000, idle clk cycles allowed between bytes of one frame (50 ms) before the partial frame is discarded.

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active high
rx_byte  in  8  byte from UART receiver, valid while rx_rdy high
rx_rdy  in  1  receiver has a byte; held until clr_rx_rdy
clr_rx_rdy  out  1  one-cycle pulse acknowledging rx_byte
cmd  out  8  opcode of last complete frame
data  out  16  {hi,lo} data of last complete frame
cmd_rdy  out  1  complete frame available
clr_cmd_rdy  in  1  consumer acknowledges cmd/data
frame_err  out  1  one-cycle pulse when a partial frame times out
resp  in  8  response byte to transmit
send_resp  in  1  start response transmission (sampled only when idle)
resp_sent  out  1  one-cycle pulse at end of stop bit
tx_busy  out  1  transmission in progress
TX  out  1  serial out, idle high

Behaviour:
- Reset (sync, rst high at a rising edge), values from the next cycle:
  - cmd=0, data=0, cmd_rdy=0.
  - clr_rx_rdy=0, frame_err=0, resp_sent=0, tx_busy=0, TX=1.
  - Both FSMs go to their idle states.
  - Reset mid-frame discards partial bytes. Reset mid-transmit drives TX=1 on the next cycle; no resp_sent pulse.
- Receive FSM, states WAIT_CMD, WAIT_HI, WAIT_LO:
  - A byte is accepted in any cycle where rx_rdy=1. clr_rx_rdy is asserted combinationally in that same cycle for exactly one cycle.
  - WAIT_CMD, accept: capture the byte into a shadow opcode, clear cmd_rdy, go to WAIT_HI.
  - WAIT_HI, accept: capture the high byte, go to WAIT_LO.
  - WAIT_LO, accept: load cmd <= shadow opcode and data <= {hi, rx_byte}, set cmd_rdy (visible the cycle after acceptance), go to WAIT_CMD.
  - cmd/data change only on frame completion and are stable while cmd_rdy=1.
- cmd_rdy rules:
  - Cleared by clr_cmd_rdy, or by acceptance of the next opcode byte.
  - If frame completion and clr_cmd_rdy occur in the same cycle, the set wins (cmd_rdy=1).
- Timeout:
  - A 22-bit counter clears on every accepted byte and increments in WAIT_HI/WAIT_LO.
  - On reaching FRAME_TMO: go to WAIT_CMD, pulse frame_err for 1 cycle, leave cmd/data/cmd_rdy unchanged.
  - The counter is held at 0 in WAIT_CMD.
- Transmit FSM, states TX_IDLE, TX_SHIFT:
  - In TX_IDLE with send_resp=1: load the 10-bit frame {1, resp, 0}, set tx_busy, go to TX_SHIFT.
  - TX drives the frame LSB first: start bit 0, data bits resp[0]..resp[7], then stop bit 1.
  - Each bit lasts exactly BAUD_DIV cycles, using a 12-bit baud counter and a 4-bit bit counter.
  - After the 10th bit period: pulse resp_sent for one cycle, clear tx_busy, return to TX_IDLE.
  - TX falls the cycle after send_resp is sampled.
  - send_resp while tx_busy=1 is ignored; no queueing.
  - send_resp in the same cycle as resp_sent is ignored; it is accepted one cycle later.
- Independence: receive and transmit operate concurrently; a frame may arrive during transmission.

Decomposition:
- Shared package comm_pkg:
  - Opcode localparams REQ_BATT=8'h01, SET_PTCH=8'h02, SET_ROLL=8'h03, SET_YAW=8'h04, SET_THRST=8'h05, CALIBRATE=8'h06, EMER_LAND=8'h07, MTRS_OFF=8'h08.
  - POS_ACK=8'hA5.
  - typedef enums rx_state_t and tx_state_t.
- One sub-module: resp_uart_tx. It contains the transmit FSM, baud counter and shift register. Its ports are clk, rst, resp, send_resp, TX, tx_busy and resp_sent, and it is parameterised by BAUD_DIV.
- Frame assembly stays in the top level.

Test Plan:
1. Frame assembly: bytes 8'h02, 8'h00, 8'h3A, each with rx_rdy held until clr_rx_rdy -> three single-cycle clr_rx_rdy pulses; cmd_rdy=1 one cycle after the third; cmd=8'h02, data=16'h003A.
2. Second frame, no clear: 8'h04/8'h80/8'h0A with cmd_rdy still high from frame 1 -> cmd_rdy drops when 8'h04 is accepted, cmd/data hold 02/003A until completion, then cmd=8'h04, data=16'h800A, cmd_rdy=1.
3. Simultaneous set/clear: clr_cmd_rdy pulsed in the same cycle the low byte is accepted -> cmd_rdy=1 afterwards. A later clr_cmd_rdy -> cmd_rdy=0 next cycle.
4. Timeout (FRAME_TMO overridden to 100): send only 8'h05, 8'h00, then wait 100 cycles -> one frame_err pulse and cmd_rdy unchanged. Then 8'h05/8'h00/8'hFD -> cmd=8'h05, data=16'h00FD.
5. Response transmit (BAUD_DIV=16): resp=8'hA5 with send_resp for 1 cycle ->
   - TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
   - tx_busy high for 160 cycles, resp_sent pulses once.
   - A second send_resp (8'hC0) mid-frame is ignored.
6. Reset mid-operation: assert rst during the 5th TX bit and after the opcode byte -> next cycle TX=1, tx_busy=0, no resp_sent. A subsequent full 3-byte frame assembles correctly.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the copter command link: opcodes, the ack byte,
// and the state encodings used by the frame receiver and the response transmitter.
package comm_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] POS_ACK   = 8'hA5;

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/cmd_frame_responder_if.sv
// Byte-level link between the UART receiver, the command processor and the
// response path. slave is the responder's view, master is the environment's.
interface cmd_frame_responder_if;

    logic [7:0]  rx_byte;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frame_err;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        TX;

    modport slave (
        input  rx_byte, rx_rdy, clr_cmd_rdy, resp, send_resp,
        output clr_rx_rdy, cmd, data, cmd_rdy, frame_err, resp_sent, tx_busy, TX
    );

    modport master (
        output rx_byte, rx_rdy, clr_cmd_rdy, resp, send_resp,
        input  clr_rx_rdy, cmd, data, cmd_rdy, frame_err, resp_sent, tx_busy, TX
    );

endinterface

// File: rtl/resp_uart_tx.sv
// 8N1 serialiser for the single response byte; one request is taken only
// while idle and completion is flagged during the last cycle of the stop bit.
module resp_uart_tx
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp,
    input  logic       send_resp,
    output logic       TX,
    output logic       tx_busy,
    output logic       resp_sent
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'd9;

    tx_state_t   state_q, state_d;
    logic [11:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [9:0]  shift_q, shift_d;
    logic        bit_end;
    logic        frame_end;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = bit_end && (bit_q == LAST_BIT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:  if (send_resp) state_d = TX_SHIFT;
            TX_SHIFT: if (frame_end) state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        TX        = 1'b1;
        tx_busy   = 1'b0;
        resp_sent = 1'b0;
        if (state_q == TX_SHIFT) begin
            TX        = shift_q[0];
            tx_busy   = 1'b1;
            resp_sent = frame_end;
        end
    end

    // Frame is {stop, data, start}; shifting in ones keeps the line at mark.
    always_comb begin
        baud_d  = '0;
        bit_d   = '0;
        shift_d = shift_q;
        if (state_q == TX_IDLE) begin
            if (send_resp) shift_d = {1'b1, resp, 1'b0};
        end else if (bit_end) begin
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b1, shift_q[9:1]};
        end else begin
            baud_d  = baud_q + 12'd1;
            bit_d   = bit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/cmd_frame_responder.sv
// Copter-side command link endpoint: builds opcode/hi/lo frames from the UART
// receiver and sends one-byte responses back over the serial line.
module cmd_frame_responder
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 2604,
    parameter logic [21:0] FRAME_TMO = 22'd2500000
) (
    input  logic                   clk,
    input  logic                   rst,
    cmd_frame_responder_if.slave   bus
);

    localparam logic [21:0] TMO_LAST = FRAME_TMO - 22'd1;

    rx_state_t   state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [21:0] tmo_q, tmo_d;
    logic        frame_err_q, frame_err_d;

    logic accept;
    logic ld_op, ld_hi, ld_frame;
    logic tmo_hit;

    assign accept  = bus.rx_rdy;
    assign tmo_hit = (state_q != WAIT_CMD) && !accept && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_CMD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_CMD: if (accept) state_d = WAIT_HI;
            WAIT_HI: begin
                if (accept)       state_d = WAIT_LO;
                else if (tmo_hit) state_d = WAIT_CMD;
            end
            WAIT_LO: begin
                if (accept || tmo_hit) state_d = WAIT_CMD;
            end
            default: state_d = WAIT_CMD;
        endcase
    end

    always_comb begin
        bus.clr_rx_rdy = accept;
        ld_op          = accept && (state_q == WAIT_CMD);
        ld_hi          = accept && (state_q == WAIT_HI);
        ld_frame       = accept && (state_q == WAIT_LO);
    end

    // A completed frame overrides a same-cycle consumer clear.
    always_comb begin
        op_d        = ld_op ? bus.rx_byte : op_q;
        hi_d        = ld_hi ? bus.rx_byte : hi_q;
        cmd_d       = ld_frame ? op_q : cmd_q;
        data_d      = ld_frame ? {hi_q, bus.rx_byte} : data_q;
        frame_err_d = tmo_hit;

        cmd_rdy_d = cmd_rdy_q;
        if (bus.clr_cmd_rdy || ld_op) cmd_rdy_d = 1'b0;
        if (ld_frame)                 cmd_rdy_d = 1'b1;

        if (accept || state_q == WAIT_CMD || tmo_hit) tmo_d = '0;
        else                                          tmo_d = tmo_q + 22'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            hi_q        <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            hi_q        <= hi_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.data      = data_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.frame_err = frame_err_q;

    resp_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .resp      (bus.resp),
        .send_resp (bus.send_resp),
        .TX        (bus.TX),
        .tx_busy   (bus.tx_busy),
        .resp_sent (bus.resp_sent)
    );

endmodule

// File: tb/tb_cmd_frame_responder.sv
// Directed bench for cmd_frame_responder with short baud and timeout values;
// expected values are hand-derived constants.
module tb_cmd_frame_responder;
    import comm_pkg::*;

    localparam int unsigned BAUD     = 16;
    localparam logic [21:0] TMO      = 22'd100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cmd_frame_responder_if bus ();

    cmd_frame_responder #(
        .BAUD_DIV  (BAUD),
        .FRAME_TMO (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one byte for a single accepting edge, optionally with a consumer clear.
    task automatic send_byte(input logic [7:0] b, input logic clr);
        bus.rx_byte     = b;
        bus.rx_rdy      = 1'b1;
        bus.clr_cmd_rdy = clr;
        #1;
        check("clr_rx_rdy_on", 32'(bus.clr_rx_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_rdy      = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        #1;
        check("clr_rx_rdy_off", 32'(bus.clr_rx_rdy), 32'd0);
    endtask

    logic [9:0] frame;
    int tx_err, busy_cnt, sent_cnt, sent_at, err_cnt;
    logic exp_tx;

    initial begin
        bus.rx_byte     = '0;
        bus.rx_rdy      = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp        = '0;
        bus.send_resp   = 1'b0;

        // Reset state
        idle(3);
        rst = 1'b0;
        #1;
        check("rst_cmd",       32'(bus.cmd),        32'h0);
        check("rst_data",      32'(bus.data),       32'h0);
        check("rst_cmd_rdy",   32'(bus.cmd_rdy),    32'd0);
        check("rst_clr_rx",    32'(bus.clr_rx_rdy), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err),  32'd0);
        check("rst_resp_sent", 32'(bus.resp_sent),  32'd0);
        check("rst_tx_busy",   32'(bus.tx_busy),    32'd0);
        check("rst_TX",        32'(bus.TX),         32'd1);
        idle(2);

        // 1: basic frame assembly
        send_byte(SET_PTCH, 1'b0);
        idle(1);
        send_byte(8'h00, 1'b0);
        check("f1_rdy_early", 32'(bus.cmd_rdy), 32'd0);
        idle(2);
        send_byte(8'h3A, 1'b0);
        check("f1_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("f1_cmd",     32'(bus.cmd),     32'h02);
        check("f1_data",    32'(bus.data),    32'h003A);
        idle(2);

        // 2: next opcode drops cmd_rdy; outputs hold until completion
        send_byte(SET_YAW, 1'b0);
        check("f2_rdy_drop", 32'(bus.cmd_rdy), 32'd0);
        check("f2_cmd_hold", 32'(bus.cmd),     32'h02);
        send_byte(8'h80, 1'b0);
        check("f2_data_hold", 32'(bus.data),   32'h003A);
        send_byte(8'h0A, 1'b0);
        check("f2_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("f2_cmd",     32'(bus.cmd),     32'h04);
        check("f2_data",    32'(bus.data),    32'h800A);
        idle(2);

        // 3: set beats a same-cycle clear; a lone clear then drops cmd_rdy
        send_byte(REQ_BATT, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b1);
        check("f3_set_wins", 32'(bus.cmd_rdy), 32'd1);
        check("f3_cmd",      32'(bus.cmd),     32'h01);
        check("f3_data",     32'(bus.data),    32'h55AA);
        idle(2);
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b0;
        check("f3_clear", 32'(bus.cmd_rdy), 32'd0);
        idle(2);

        // 4: partial frame times out, then a full frame still assembles
        send_byte(SET_THRST, 1'b0);
        send_byte(8'h00, 1'b0);
        err_cnt = 0;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_err) err_cnt++;
        end
        check("tmo_early", 32'(err_cnt), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_err) err_cnt++;
        end
        check("tmo_pulse",   32'(err_cnt),     32'd1);
        check("tmo_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        check("tmo_cmd",     32'(bus.cmd),     32'h01);
        check("tmo_data",    32'(bus.data),    32'h55AA);
        send_byte(SET_THRST, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFD, 1'b0);
        check("f4_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("f4_cmd",     32'(bus.cmd),     32'h05);
        check("f4_data",    32'(bus.data),    32'h00FD);
        idle(2);

        // 5: response transmit, with an ignored request mid-frame
        frame = {1'b1, POS_ACK, 1'b0};
        bus.resp      = POS_ACK;
        bus.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
        tx_err = 0; busy_cnt = 0; sent_cnt = 0; sent_at = -1;
        for (int cyc = 0; cyc < 180; cyc++) begin
            exp_tx = (cyc < 160) ? frame[cyc / 16] : 1'b1;
            if (bus.TX !== exp_tx) tx_err++;
            if (cyc < 160 && (cyc % 16) == 8) check("tx_bit", 32'(bus.TX), 32'(exp_tx));
            if (bus.tx_busy) busy_cnt++;
            if (bus.resp_sent) begin
                sent_cnt++;
                sent_at = cyc;
            end
            if (cyc == 50) begin
                bus.resp      = 8'hC0;
                bus.send_resp = 1'b1;
            end
            if (cyc == 51) bus.send_resp = 1'b0;
            @(posedge clk);
            #1;
        end
        check("tx_bit_width",  32'(tx_err),   32'd0);
        check("tx_busy_len",   32'(busy_cnt), 32'd160);
        check("tx_sent_count", 32'(sent_cnt), 32'd1);
        check("tx_sent_cycle", 32'(sent_at),  32'd159);
        idle(2);

        // 6: reset during 5th TX bit with a partial frame pending
        send_byte(SET_ROLL, 1'b0);
        bus.resp      = POS_ACK;
        bus.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
        idle(70);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst6_TX",      32'(bus.TX),      32'd1);
        check("rst6_tx_busy", 32'(bus.tx_busy), 32'd0);
        check("rst6_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        check("rst6_cmd",     32'(bus.cmd),     32'h0);
        sent_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.resp_sent) sent_cnt++;
            if (bus.frame_err) err_cnt++;
            @(posedge clk);
            #1;
        end
        check("rst6_no_sent", 32'(sent_cnt), 32'd0);
        check("rst6_no_tmo",  32'(err_cnt),  32'd0);
        send_byte(CALIBRATE, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        check("f6_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        check("f6_cmd",     32'(bus.cmd),     32'h06);
        check("f6_data",    32'(bus.data),    32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
